// File: rtl/ecg_buf_ctrl.sv
// ECG sample buffer: circular FIFO over a dual-port BRAM, 3-cycle read path.
// Optional drop counter enabled by defining ECG_OVF_CNT_EN.
module ecg_buf_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              S_valid,
  input  logic [DATA_W-1:0] S_data,
  output logic              S_ready,
  input  logic              R_req,
  output logic              R_busy,
  output logic              R_valid,
  output logic [DATA_W-1:0] R_data,
  output logic [ADDR_W:0]   Count,
  output logic [15:0]       Ovf_cnt,
  output logic              Ena,
  output logic              Wea,
  output logic [ADDR_W-1:0] Addra,
  output logic [DATA_W-1:0] Dina,
  output logic              Enb,
  output logic              Web,
  output logic [ADDR_W-1:0] Addrb,
  input  logic [DATA_W-1:0] Doutb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LAT  = 2'd2
  } rd_st_e;

  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  rd_st_e              r_state;
  rd_st_e              w_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_enb;
  logic [ADDR_W-1:0]   r_addrb;
  logic                r_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_full;
  logic                w_wr;
  logic                w_acc;
  logic                w_drop;

  assign w_full = (r_count == FULL_LVL);
  // A full buffer drops the sample even if a read is accepted this cycle.
  assign w_wr   = S_valid & ~w_full & ~Flush;
  assign w_acc  = (r_state == IDLE) & R_req
                & (r_count != '0) & ~Flush;
  assign w_drop = S_valid & w_full;

  assign S_ready = ~w_full;
  assign Ena     = w_wr;
  assign Wea     = w_wr;
  assign Addra   = r_wr_ptr;
  assign Dina    = S_data;
  assign Web     = 1'b0;
  assign Enb     = r_enb;
  assign Addrb   = r_addrb;
  assign R_busy  = (r_state != IDLE);
  assign R_valid = r_valid;
  assign R_data  = r_rdata;
  assign Count   = r_count;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = RD;
      RD:      w_next = LAT;
      LAT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (Flush) w_next = IDLE;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr, w_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_enb   <= 1'b0;
      r_addrb <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_enb   <= w_acc;
      if (w_acc) r_addrb <= r_rd_ptr;
      r_valid <= (r_state == LAT) & ~Flush;
      if ((r_state == LAT) && !Flush) r_rdata <= Doutb;
    end
  end

`ifdef ECG_OVF_CNT_EN
  logic [15:0] r_ovf;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ovf <= '0;
    end else if (w_drop && (r_ovf != 16'hFFFF)) begin
      r_ovf <= r_ovf + 16'd1;
    end
  end

  assign Ovf_cnt = r_ovf;
`else
  logic w_unused_drop;

  assign w_unused_drop = w_drop;
  assign Ovf_cnt       = '0;
`endif

endmodule

// File: tb/tb_ecg_buf_ctrl.sv
// Scoreboard bench for ecg_buf_ctrl with a queue-based reference model.
// A behavioural BRAM with one-cycle registered read sits on the ports.
module tb_ecg_buf_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          Clk;
  logic          Rst_n;
  logic          Flush;
  logic          S_valid;
  logic [DW-1:0] S_data;
  logic          S_ready;
  logic          R_req;
  logic          R_busy;
  logic          R_valid;
  logic [DW-1:0] R_data;
  logic [AW:0]   Count;
  logic [15:0]   Ovf_cnt;
  logic          Ena;
  logic          Wea;
  logic [AW-1:0] Addra;
  logic [DW-1:0] Dina;
  logic          Enb;
  logic          Web;
  logic [AW-1:0] Addrb;
  logic [DW-1:0] Doutb;

  ecg_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .S_valid(S_valid), .S_data(S_data), .S_ready(S_ready),
    .R_req(R_req), .R_busy(R_busy), .R_valid(R_valid),
    .R_data(R_data), .Count(Count), .Ovf_cnt(Ovf_cnt),
    .Ena(Ena), .Wea(Wea), .Addra(Addra), .Dina(Dina),
    .Enb(Enb), .Web(Web), .Addrb(Addrb), .Doutb(Doutb)
  );

  logic [DW-1:0] mem [0:DEPTH-1];

  always @(posedge Clk) begin
    if (Ena && Wea) mem[Addra] <= Dina;
    if (Enb) Doutb <= mem[Addrb];
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    int            addr;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] m_fifo[$];
  int            m_count;
  int            m_wcnt;
  int            m_rcnt;
  int            m_busy_until;
  int            m_ovf;
  logic [DW-1:0] m_rdata;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            done = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_fifo.delete();
    m_count      = 0;
    m_wcnt       = 0;
    m_rcnt       = 0;
    m_busy_until = 0;
    m_ovf        = 0;
    m_rdata      = '0;
  endtask

  task automatic step(input bit sv, input logic [DW-1:0] sd,
                      input bit rq, input bit fl);
    int  n;
    bit  ew;
    bit  acc;
    rd_t e;
    @(negedge Clk);
    S_valid = sv;
    S_data  = sd;
    R_req   = rq;
    Flush   = fl;
    #1;
    n  = cyc;
    ew = sv && (m_count != DEPTH) && !fl;
    chk("ena", Ena, ew);
    chk("wea", Wea, ew);
    chk("web", Web, 1'b0);
    if (ew) begin
      chk("addra", Addra, m_wcnt % DEPTH);
      chk("dina", Dina, sd);
    end
`ifdef ECG_OVF_CNT_EN
    if (sv && m_count == DEPTH && m_ovf != 16'hFFFF) m_ovf++;
`endif
    if (fl) begin
      m_fifo.delete();
      m_wcnt       = 0;
      m_rcnt       = 0;
      m_busy_until = 0;
      while (pend.size() > 0 && pend[pend.size()-1].due > n)
        void'(pend.pop_back());
    end else begin
      acc = rq && (m_count != 0) && (n >= m_busy_until);
      if (acc) begin
        e.due  = n + 3;
        e.data = m_fifo.pop_front();
        e.addr = m_rcnt % DEPTH;
        pend.push_back(e);
        m_rcnt++;
        m_busy_until = n + 3;
      end
      if (ew) begin
        m_fifo.push_back(sd);
        m_wcnt++;
      end
    end
    m_count = m_fifo.size();
    @(posedge Clk);
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compares registered outputs against the model each cycle.
  always @(negedge Clk) begin
    bit exp_rv;
    bit exp_busy;
    bit exp_enb;
    if (Rst_n && !done) begin
      exp_rv   = pend.size() > 0 && cyc == pend[0].due;
      exp_enb  = pend.size() > 0 && cyc == pend[0].due - 2;
      exp_busy = pend.size() > 0 &&
                 (cyc == pend[0].due - 2 || cyc == pend[0].due - 1);
      chk("r_valid", R_valid, exp_rv);
      chk("r_busy", R_busy, exp_busy);
      chk("enb", Enb, exp_enb);
      if (exp_enb) chk("addrb", Addrb, pend[0].addr);
      if (exp_rv) begin
        m_rdata = pend[0].data;
        void'(pend.pop_front());
      end
      chk("r_data", R_data, m_rdata);
      chk("count", Count, m_count);
      chk("s_ready", S_ready, m_count != DEPTH);
      chk("ovf_cnt", Ovf_cnt, m_ovf);
    end
  end

  initial begin
    Rst_n   = 1'b0;
    Flush   = 1'b0;
    S_valid = 1'b0;
    S_data  = '0;
    R_req   = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_count", Count, 0);
    chk("rst_rvalid", R_valid, 0);
    chk("rst_rbusy", R_busy, 0);
    chk("rst_rdata", R_data, 0);
    chk("rst_enb", Enb, 0);
    chk("rst_addrb", Addrb, 0);
    chk("rst_ovf", Ovf_cnt, 0);
    chk("rst_sready", S_ready, 1);
    #1 Rst_n = 1'b1;

    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(4);
    repeat (2) begin
      step(1'b0, '0, 1'b1, 1'b0);
      idle(3);
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    repeat (5) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0);
    idle(4);
    step(1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < DEPTH - 1; i++)
      step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 32'hAAAA_0FFF, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB_0000, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle(2);
    repeat (3 * DEPTH + 6) step(1'b0, '0, 1'b1, 1'b0);

    repeat (3000)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0);
    idle(4);

    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h5151, 1'b0, 1'b0);
    step(1'b1, 32'h5252, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge Clk);
    S_valid = 1'b0;
    R_req   = 1'b0;
    Flush   = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_rbusy", R_busy, 0);
    chk("arst_rvalid", R_valid, 0);
    chk("arst_count", Count, 0);
    chk("arst_enb", Enb, 0);
    chk("arst_sready", S_ready, 1);
    model_reset();
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    idle(5);

    step(1'b1, 32'h7171, 1'b0, 1'b0);
    step(1'b1, 32'h7272, 1'b0, 1'b0);
    step(1'b1, 32'h7373, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 32'h8181, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(5);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ecg_buf_ctrl.md
ECG_BUF_CTRL -- requirements
Module: ecg_buf_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, memory address width (depth 2^ADDR_W words).
REQ-002 The block SHALL have parameter DATA_W, default 32, sample/memory word width.
REQ-003 The block SHALL have port Clk  input  1  the single clock; all logic rising-edge.
REQ-004 The block SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port Flush  input  1  synchronous clear of pointers and count.
REQ-006 The block SHALL have port S_valid  input  1  writer offers a sample.
REQ-007 The block SHALL have port S_data  input  DATA_W  writer sample.
REQ-008 The block SHALL have port S_ready  output  1  buffer can accept a sample (not full).
REQ-009 The block SHALL have port R_req  input  1  reader requests the oldest sample.
REQ-010 The block SHALL have port R_busy  output  1  read in flight; R_req ignored.
REQ-011 The block SHALL have port R_valid  output  1  one-cycle pulse; R_data holds the sample.
REQ-012 The block SHALL have port R_data  output  DATA_W  sample returned to the reader.
REQ-013 The block SHALL have port Count  output  ADDR_W+1  words stored.
REQ-014 The block SHALL have port Ovf_cnt  output  16  dropped-sample counter.
REQ-015 The block SHALL have ports Ena, Wea  output  1 each; Addra  output  ADDR_W; Dina  output  DATA_W (BRAM port A, write).
REQ-016 The block SHALL have ports Enb, Web  output  1 each; Addrb  output  ADDR_W (BRAM port B, read); Doutb  input  DATA_W.

Function
REQ-017 The block SHALL run the BRAM as a circular FIFO: wr_ptr and rd_ptr (ADDR_W bits) wrap from 2^ADDR_W-1 to 0.
REQ-018 S_ready SHALL equal (Count != 2^ADDR_W); a write SHALL occur in any cycle with S_valid and S_ready high.
REQ-019 Write: Ena=Wea=1, Addra=wr_ptr, Dina=S_data driven combinationally in the accepting cycle; wr_ptr increments at that edge.
REQ-020 Web SHALL be constant 0; port B never writes.
REQ-021 Read FSM states SHALL be IDLE, RD, LAT; R_busy=1 in RD and LAT.
REQ-022 IDLE->RD when R_req=1 and Count!=0 (accept at edge of cycle T); rd_ptr increments at that edge; R_req while Count==0 or not IDLE SHALL be ignored.
REQ-023 In RD (cycle T+1) Enb=1 and Addrb=old rd_ptr, both registered; RD->LAT unconditionally.
REQ-024 In LAT (T+2) Doutb SHALL be captured into R_data at the edge; LAT->IDLE; R_valid=1 during T+3 only.
REQ-025 Latency accept-to-R_valid SHALL be 3 cycles; a new R_req SHALL be acceptable in T+3.
REQ-026 Count SHALL +1 on write only, -1 on accept only, unchanged on both in the same cycle.
REQ-027 A write while full SHALL be dropped (no BRAM write); simultaneous read accept does not make room that cycle.
REQ-028 R_data SHALL hold its value until the next capture.
REQ-029 Flush SHALL zero pointers, Count, FSM (to IDLE) and suppress an in-flight R_valid; Ovf_cnt, R_data unaffected; Flush overrides a simultaneous write/accept.

Reset
REQ-030 Rst_n low SHALL asynchronously force: pointers 0, Count 0, FSM IDLE, R_valid 0, R_busy 0, R_data 0, Enb 0, Addrb 0, Ovf_cnt 0.
REQ-031 Reset mid-read SHALL abort the read with no R_valid after release; S_ready=1 while in reset.

Configuration
REQ-032 With macro ECG_OVF_CNT_EN defined, Ovf_cnt SHALL increment on each dropped sample (S_valid and full), saturating at 16'hFFFF.
REQ-033 Without ECG_OVF_CNT_EN, Ovf_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-034 Reset, write 3 samples 0x11,0x22,0x33 -> Addra 0,1,2 with Wea=1; Count=3.
REQ-035 R_req in T with Count=3 -> Enb=1, Addrb=0 in T+1; R_valid and R_data=0x11 in T+3; Count=2.
REQ-036 Fill 4096 words -> S_ready=0, Count=4096; one extra S_valid -> no Ena, Ovf_cnt=1 (macro on) / 0 (off).
REQ-037 wr_ptr at 4095, write then read across wrap -> Addra 4095 then 0; reads return in order.
REQ-038 Write and read accept same cycle at Count=5 -> Count stays 5; R_req with Count=0 -> no R_busy, no R_valid.
REQ-039 Rst_n low in LAT -> immediate R_busy=0, no R_valid after release; Flush in RD -> same, Count=0.
